arb_req_queue_4: RTL and testbench
==================================

Name: arb_req_queue_4

Overview:
- Request-side front end placed directly upstream of the 4-input arbiter.
- Holds one small FIFO per requester. Drives the arbiter's `req[3:0]` from FIFO non-empty status.
- Consumes the arbiter's one-hot `grant[3:0]` to pop the granted head entry onto a single registered output channel.

Parameters:
- DATA_W, 8, payload width per request entry.
- DEPTH, 4, entries per requester FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-requester push strobe.
- in_ready  output  4  per-requester FIFO not full.
- in_data  input  4*DATA_W  payloads; requester i uses bits [i*DATA_W +: DATA_W].
- req  output  4  request vector to the arbiter; req[i] = FIFO i non-empty.
- grant  input  4  one-hot grant from the arbiter.
- out_valid  output  1  registered pulse; one popped entry is presented.
- out_data  output  DATA_W  payload of the popped entry.
- out_src  output  2  index of the FIFO that was popped.
- err  output  1  sticky grant-protocol error (see Optional Feature).

Behaviour:
- Reset:
  - All FIFOs are emptied: count, rd_ptr and wr_ptr all go to 0.
  - After reset: `req` = 0, `in_ready` = 4'hF, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `err` = 0.
  - Reset asserted mid-operation discards all queued entries immediately; no pop is produced.
- Per-FIFO state: circular buffer, `count` of width $clog2(DEPTH)+1, read and write pointers that wrap modulo DEPTH.
- Push:
  - Occurs when in_valid[i] && in_ready[i].
  - `in_ready[i]` = (count_i != DEPTH); it is computed from registered count only, so there is no same-cycle pop bypass.
  - in_valid while full is dropped silently; count and data are unchanged.
- Request: `req[i]` = (count_i != 0), combinational from registered state.
  - A pushed entry raises req on the cycle after the push edge.
- Pop selection:
  - Each cycle, sel = lowest index i with grant[i] && count_i != 0.
  - If sel exists, FIFO sel pops at the clock edge.
  - Any other granted queues are ignored.
  - A grant to an empty queue is ignored.
- Output (latency 1 cycle from grant sample to out_valid):
  - Cycle after a pop: out_valid = 1, out_data = popped head, out_src = sel.
  - Cycle with no pop: out_valid = 0; out_data and out_src hold their last values.
  - There is no output backpressure; the downstream consumer must accept every pulse.
- Simultaneous push and pop on the same FIFO: count is unchanged, both pointers advance, and ordering is preserved.
- Push into an empty FIFO while grant[i] is high in the same cycle: no pop that cycle, because count_i was 0.
- Back-to-back grants to the same FIFO pop one entry per cycle until it is empty. req[i] falls on the cycle after the last pop.
- FIFOs are strictly FIFO; entries never reorder within a requester.

Optional Feature:
- Macro: ARB_REQ_QUEUE_GRANT_CHECK_EN.
- Defined:
  - `err` is set and stays set until reset if, on any cycle, grant has more than one bit set, or grant[i] = 1 while count_i = 0.
  - Simulation builds also fire an assertion on the same condition.
- Undefined: `err` is tied to 0 and the check logic is not compiled in. Pop selection is identical in both builds.

Test Plan:
- Reset, then push 8'hA1 into FIFO 2 with no grant -> in the next cycle req = 4'b0100; out_valid stays 0.
- FIFO 2 holds A1 then A2; grant = 4'b0100 for 2 cycles -> out_valid pulses on 2 consecutive cycles with out_data A1 then A2, out_src = 2; req[2] = 0 after the second pop.
- Push 4 entries into FIFO 0 with DEPTH = 4 -> in_ready[0] = 0; a fifth push of 8'hFF is dropped. Grant 4 times -> out_data 0..3 in order; 8'hFF never appears.
- Same-cycle push and grant on FIFO 1 holding 1 entry -> count stays 1, the old entry is output, and the new entry is output on the next grant.
- grant = 4'b1010 with both FIFO 1 and FIFO 3 non-empty -> only FIFO 1 pops, out_src = 1. With ARB_REQ_QUEUE_GRANT_CHECK_EN defined, err = 1 and stays 1.
- Assert rst_n low while FIFO 3 holds 3 entries -> req = 0 and in_ready = 4'hF immediately; a grant after reset produces no out_valid.

Source files
------------

// File: rtl/arb_req_queue_4.sv
// arb_req_queue_4
//   Request-side front end for a 4-input arbiter. Each requester owns a small
//   circular FIFO. req[i] reflects FIFO i non-empty, and the arbiter's one-hot
//   grant pops the granted head onto a single registered output channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; empties every FIFO
//   in_valid   per-requester push strobe
//   in_ready   per-requester FIFO not full (registered count only)
//   in_data    payloads; requester i on bits [i*DATA_W +: DATA_W]
//   req        request vector to the arbiter; FIFO i non-empty
//   grant      one-hot grant from the arbiter
//   out_valid  one-cycle pulse per popped entry
//   out_data   payload of the popped entry (held when idle)
//   out_src    index of the popped FIFO (held when idle)
//   err        sticky grant-protocol error
//
// Build option
//   ARB_REQ_QUEUE_GRANT_CHECK_EN : when defined, err latches on a multi-hot
//   grant or on a grant to an empty FIFO, and simulation asserts on it.
//   When undefined, err is tied low. Pop selection is the same in both builds.

module arb_req_queue_4 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]        req,
  input  logic [3:0]        grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [CNT_W-1:0]  count  [4];
  logic [PTR_W-1:0]  rd_ptr [4];
  logic [PTR_W-1:0]  wr_ptr [4];

  logic [3:0] push;
  logic [3:0] pop;
  logic       sel_valid;
  logic [1:0] sel_idx;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = (count[i] != FULL_CNT);
      req[i]      = (count[i] != '0);
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Scan from the top down so the lowest granted non-empty queue wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (grant[i] && req[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    pop = 4'b0000;
    if (sel_valid) pop[sel_idx] = 1'b1;
  end

  // Storage is not reset; occupancy is tracked entirely by count/pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CNT_W'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
    end else begin
      out_valid <= sel_valid;
      if (sel_valid) begin
        out_data <= mem[sel_idx][rd_ptr[sel_idx]];
        out_src  <= sel_idx;
      end
    end
  end

`ifdef ARB_REQ_QUEUE_GRANT_CHECK_EN
  logic grant_bad;
  logic err_q;

  assign grant_bad = ((grant & (grant - 4'd1)) != 4'd0) || ((grant & ~req) != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (grant_bad) err_q <= 1'b1;
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!grant_bad)
        else $error("arb_req_queue_4: grant protocol violation grant=%b req=%b", grant, req);
    end
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_req_queue_4.sv
module tb_arb_req_queue_4;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [3:0]        in_valid;
  logic [3:0]        in_ready;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]        req;
  logic [3:0]        grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_src;
  logic              err;

  int n_vec;
  int n_err;

`ifdef ARB_REQ_QUEUE_GRANT_CHECK_EN
  localparam logic ERR_ON_MULTI = 1'b1;
`else
  localparam logic ERR_ON_MULTI = 1'b0;
`endif

  arb_req_queue_4 #(.DATA_W(DATA_W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DATA_W-1:0] val);
    in_data[idx*DATA_W +: DATA_W] = val;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 4'b0000;
    in_data  = '0;
    grant    = 4'b0000;

    #2;
    chk("rst_req",       32'(req),       32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'hF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_src",   32'(out_src),   32'h0);
    chk("rst_err",       32'(err),       32'h0);
    #10;
    rst_n = 1'b1;
    step();

    // Push A1 into FIFO 2, no grant.
    set_data(2, 8'hA1);
    in_valid = 4'b0100;
    step();
    chk("t1_req",       32'(req),       32'h4);
    chk("t1_out_valid", 32'(out_valid), 32'h0);

    // Add A2, then grant FIFO 2 twice.
    set_data(2, 8'hA2);
    step();
    in_valid = 4'b0000;
    grant    = 4'b0100;
    step();
    chk("t2_v0",    32'(out_valid), 32'h1);
    chk("t2_d0",    32'(out_data),  32'hA1);
    chk("t2_s0",    32'(out_src),   32'h2);
    chk("t2_req0",  32'(req),       32'h4);
    step();
    chk("t2_v1",    32'(out_valid), 32'h1);
    chk("t2_d1",    32'(out_data),  32'hA2);
    chk("t2_req1",  32'(req),       32'h0);
    grant = 4'b0000;
    step();
    chk("t2_idle_v",    32'(out_valid), 32'h0);
    chk("t2_hold_data", 32'(out_data),  32'hA2);
    chk("t2_hold_src",  32'(out_src),   32'h2);

    // Fill FIFO 0, then a dropped push of FF.
    for (int k = 0; k < 4; k++) begin
      set_data(0, 8'(k));
      in_valid = 4'b0001;
      step();
    end
    chk("t3_full_ready", 32'(in_ready), 32'hE);
    set_data(0, 8'hFF);
    step();
    in_valid = 4'b0000;
    grant    = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_pop_v", 32'(out_valid), 32'h1);
      chk("t3_pop_d", 32'(out_data),  32'(k));
    end
    grant = 4'b0000;
    step();
    chk("t3_drained_req", 32'(req),       32'h0);
    chk("t3_no_ff",       32'(out_valid), 32'h0);

    // Same-cycle push and pop on FIFO 1 holding one entry.
    set_data(1, 8'h10);
    in_valid = 4'b0010;
    step();
    set_data(1, 8'h11);
    grant = 4'b0010;
    step();
    chk("t4_v0",    32'(out_valid), 32'h1);
    chk("t4_d0",    32'(out_data),  32'h10);
    chk("t4_s0",    32'(out_src),   32'h1);
    chk("t4_req",   32'(req),       32'h2);
    in_valid = 4'b0000;
    step();
    chk("t4_d1",    32'(out_data),  32'h11);
    chk("t4_req1",  32'(req),       32'h0);
    grant = 4'b0000;
    step();

    // Multi-hot grant with FIFOs 1 and 3 non-empty.
    set_data(1, 8'h31);
    set_data(3, 8'h33);
    in_valid = 4'b1010;
    step();
    in_valid = 4'b0000;
    grant    = 4'b1010;
    step();
    chk("t5_v",   32'(out_valid), 32'h1);
    chk("t5_src", 32'(out_src),   32'h1);
    chk("t5_d",   32'(out_data),  32'h31);
    chk("t5_req", 32'(req),       32'h8);
    grant = 4'b0000;
    step();
    chk("t5_err_sticky", 32'(err), 32'(ERR_ON_MULTI));

    // FIFO 3 to three entries, then asynchronous reset mid-cycle.
    set_data(3, 8'h34);
    in_valid = 4'b1000;
    step();
    set_data(3, 8'h35);
    step();
    in_valid = 4'b0000;
    chk("t6_pre_req", 32'(req), 32'h8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",      32'(req),       32'h0);
    chk("t6_rst_in_ready", 32'(in_ready),  32'hF);
    chk("t6_rst_err",      32'(err),       32'h0);
    #2;
    rst_n = 1'b1;
    grant = 4'b1000;
    step();
    chk("t6_no_pop", 32'(out_valid), 32'h0);
    grant = 4'b0000;

    // Push into empty FIFO 2 while granted: no pop that cycle.
    set_data(2, 8'h5A);
    in_valid = 4'b0100;
    grant    = 4'b0100;
    step();
    chk("t7_no_pop", 32'(out_valid), 32'h0);
    chk("t7_req",    32'(req),       32'h4);
    in_valid = 4'b0000;
    step();
    chk("t7_pop_v", 32'(out_valid), 32'h1);
    chk("t7_pop_d", 32'(out_data),  32'h5A);
    chk("t7_pop_s", 32'(out_src),   32'h2);
    grant = 4'b0000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
